uart_rx_ip: RTL and testbench
=============================

// Module: uart_rx_ip
// PURPOSE
//   Memory-mapped UART receiver: the receive side of the SOC serial link, driven from the RXD pin.
//   Deserialises 8N1 frames, LSB first, into a small byte FIFO.
//   The CPU reads through two IO-page words: DATA (pops one byte) and STATUS (flags, clear-on-read).
//   Status is also exported as a level interrupt.
// PARAMETERS
//   CLK_FREQ_HZ  12000000  system clock frequency
//   BAUD_RATE    9600      line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide, must be >= 4)
//   FIFO_DEPTH   4         receive FIFO entries; power of two, >= 2
// PORTS
//   clk        in   1   system clock
//   resetn     in   1   asynchronous active-low reset
//   rxd        in   1   serial input, asynchronous to clk, idle high
//   sel_data   in   1   CPU access targets the DATA word
//   sel_stat   in   1   CPU access targets the STATUS word
//   rstrb      in   1   CPU read strobe, one cycle wide
//   rdata      out  32  read data, registered
//   rx_irq     out  1   high while FIFO not empty
// BEHAVIOUR
// - Reset values:
//   - FSM IDLE, FIFO empty (pointers and count 0).
//   - overrun and frame_err cleared; rdata = 0; rx_irq = 0.
//   - Synchroniser flops reset to 1.
// - Input conditioning:
//   - rxd passes through 2-flop synchroniser -> rx_s; rx_s is registered into rx_d.
//   - Start detect = rx_d & !rx_s (falling edge).
// - Bit timer: down-counter cnt, width $clog2(CLKS_PER_BIT); sample point when cnt == 0.
// - FSM:
//   - IDLE:  on start detect, cnt <= CLKS_PER_BIT/2 - 1 -> START.
//   - START: at sample, if rx_s == 0: cnt <= CLKS_PER_BIT-1, bit index <= 0 -> DATA.
//            If rx_s == 1 (glitch): -> IDLE, nothing recorded.
//   - DATA:  at each sample, shift <= {rx_s, shift[7:1]}, cnt <= CLKS_PER_BIT-1.
//            After bit index 7 -> STOP.
//   - STOP:  at sample (mid stop bit):
//            rx_s == 1 and FIFO not full -> push byte.
//            rx_s == 1 and FIFO full (after this cycle's pop) -> drop byte, set overrun.
//            rx_s == 0 -> drop byte, set frame_err.
//            Always -> IDLE the same cycle.
//   - A held-low line (break) does not retrigger; a new frame needs a fresh falling edge.
// - CPU reads (1-cycle latency, data valid the cycle after rstrb):
//   - DATA read (rstrb & sel_data), FIFO not empty: rdata <= {23'b0, 1'b1, head}, pop.
//   - DATA read, FIFO empty: rdata <= 0, no pointer change.
//   - STATUS read (rstrb & sel_stat & !sel_data):
//     rdata <= {28'b0, frame_err, overrun, full, !empty}.
//     Clears overrun and frame_err.
//   - sel_data and sel_stat both high: DATA read only; sticky flags untouched.
//   - No read strobe: rdata holds its value.
// - Simultaneous events:
//   - Push and pop in the same cycle: both happen, count unchanged; valid even when full.
//   - Flag set and STATUS-read clear in the same cycle: set wins, flag remains 1.
//     The returned rdata shows the pre-update value.
// - FIFO: circular buffer, pointers wrap modulo FIFO_DEPTH.
//   count width $clog2(FIFO_DEPTH)+1; full when count == FIFO_DEPTH.
// - rx_irq = (count != 0), combinational from registered count.
// - resetn low mid-frame: immediate abort to IDLE; FIFO contents discarded.
//   After release, reception resumes only on the next falling edge.
// TESTING (bench: CLK_FREQ_HZ=1000000, BAUD_RATE=100000 -> 10 clks/bit, FIFO_DEPTH=4)
//   1. Send 0x55 -> rx_irq rises; STATUS=0x1; DATA=0x155; then STATUS=0x0, rx_irq=0.
//   2. rxd low for 3 clks then high -> FSM returns IDLE; STATUS=0x0; no push.
//   3. Send 0xA5 with stop bit 0 -> STATUS=0x8, FIFO empty; second STATUS read=0x0.
//   4. Send 0x01,0x02,0x03,0x04,0x05 without reading.
//      -> STATUS=0x7; DATA reads 0x101..0x104 in order; then DATA read=0x0.
//   5. FIFO full; DATA read strobed in the same cycle as a stop-bit push.
//      -> no overrun; count stays 4; new byte appears after the older three.
//   6. Assert resetn at bit 4 of 0x3C, release, send 0xC3.
//      -> only 0x1C3 read; STATUS=0x0 afterwards.

Source files
------------

// File: rtl/uart_rx_ip.sv
// uart_rx_ip: memory-mapped 8N1 UART receiver with a small byte FIFO.
//   clk, resetn        system clock, asynchronous active-low reset
//   rxd                serial input (asynchronous, idle high)
//   sel_data/sel_stat  CPU access targets DATA / STATUS word
//   rstrb              one-cycle CPU read strobe
//   rdata              registered read data (valid the cycle after rstrb)
//   rx_irq             level interrupt, high while the FIFO holds data
module uart_rx_ip #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rxd,
    input  logic        sel_data,
    input  logic        sel_stat,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        rx_irq
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W       = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic              r_sync1, r_rx_s, r_rx_d;
    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]        r_bit_idx, w_bit_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              w_push, w_frame_set, w_ovr_set;
    logic              r_overrun, r_frame_err;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [FCNT_W-1:0] r_count;
    logic              w_start, w_sample, w_empty, w_full, w_pop, w_stat_rd, w_full_eff;

    assign w_start    = r_rx_d & ~r_rx_s;
    assign w_sample   = (r_cnt == '0);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FCNT_W'(FIFO_DEPTH));
    assign w_pop      = rstrb & sel_data & ~w_empty;
    assign w_stat_rd  = rstrb & sel_stat & ~sel_data;
    // A pop in the stop-sample cycle frees the slot for the incoming byte.
    assign w_full_eff = w_full & ~w_pop;
    assign rx_irq     = ~w_empty;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // Receiver state and bit-timing registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state, bit timer and frame outcome.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_frame_set   = 1'b0;
        w_ovr_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_cnt_nxt   = CNT_W'(CLKS_PER_BIT / 2 - 1);
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else if (!r_rx_s) begin
                    w_cnt_nxt     = CNT_W'(CLKS_PER_BIT - 1);
                    w_bit_idx_nxt = 3'd0;
                    w_state_nxt   = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = CNT_W'(CLKS_PER_BIT - 1);
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!w_sample) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = S_IDLE;
                    if (!r_rx_s)        w_frame_set = 1'b1;
                    else if (w_full_eff) w_ovr_set  = 1'b1;
                    else                 w_push     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_shift_nxt;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + FCNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - FCNT_W'(1);
        end
    end

    // Sticky flags: a same-cycle set beats the STATUS-read clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set)      r_overrun <= 1'b1;
            else if (w_stat_rd) r_overrun <= 1'b0;
            if (w_frame_set)    r_frame_err <= 1'b1;
            else if (w_stat_rd) r_frame_err <= 1'b0;
        end
    end

    // CPU read port; STATUS returns pre-update flag values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else if (rstrb && sel_data) begin
            rdata <= w_empty ? 32'd0 : {23'd0, 1'b1, r_mem[r_rd_ptr]};
        end else if (w_stat_rd) begin
            rdata <= {28'd0, r_frame_err, r_overrun, w_full, ~w_empty};
        end
    end
endmodule

// File: tb/tb_uart_rx_ip.sv
module tb_uart_rx_ip;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn, rxd, sel_data, sel_stat, rstrb, rx_irq;
    logic [31:0] rdata;

    int checks = 0;
    int failures = 0;

    uart_rx_ip #(.CLK_FREQ_HZ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .rxd(rxd), .sel_data(sel_data),
        .sel_stat(sel_stat), .rstrb(rstrb), .rdata(rdata), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference model: queue of received bytes plus sticky flags.
    logic [7:0] m_q[$];
    logic       m_ovr = 1'b0;
    logic       m_fe  = 1'b0;

    function automatic void m_frame(input logic [7:0] b, input logic stop);
        if (!stop)                  m_fe = 1'b1;
        else if (m_q.size() == DEPTH) m_ovr = 1'b1;
        else                        m_q.push_back(b);
    endfunction

    function automatic logic [31:0] m_rd_data();
        logic [31:0] v;
        v = 32'd0;
        if (m_q.size() > 0) v = {23'd0, 1'b1, m_q.pop_front()};
        return v;
    endfunction

    function automatic logic [31:0] m_rd_stat();
        logic [31:0] v;
        v = {28'd0, m_fe, m_ovr, m_q.size() == DEPTH, m_q.size() != 0};
        m_fe  = 1'b0;
        m_ovr = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Drive one 10-clock-per-bit frame; optionally strobe a DATA read at cycle pop_at
    // (captured into cap) or assert reset at cycle abort_at.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                              input int abort_at, output logic [31:0] cap);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        cap = 32'd0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                resetn = 1'b0;
                break;
            end
            if (c == pop_at + 1) cap = rdata;
            rxd      = frame[c / 10];
            rstrb    = (c == pop_at);
            sel_data = (c == pop_at);
            sel_stat = 1'b0;
        end
        rxd = 1'b1; rstrb = 1'b0; sel_data = 1'b0;
        if (abort_at >= 0) begin
            repeat (3) @(negedge clk);
            resetn = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic glitch();
        @(negedge clk); rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic cpu_read(input logic sd, input logic ss, output logic [31:0] v);
        @(negedge clk);
        rstrb = 1'b1; sel_data = sd; sel_stat = ss;
        @(negedge clk);
        rstrb = 1'b0; sel_data = 1'b0; sel_stat = 1'b0;
        v = rdata;
    endtask

    typedef enum int {OP_SEND, OP_RDD, OP_RDS, OP_RDB, OP_GLITCH} op_t;

    // Apply one operation to DUT and model; is_rd says whether act/mexp are meaningful.
    task automatic do_op(input op_t op, input logic [7:0] d, input logic stop,
                         output logic [31:0] act, output logic [31:0] mexp, output logic is_rd);
        act = 32'd0; mexp = 32'd0; is_rd = 1'b1;
        case (op)
            OP_SEND:   begin send_frame(d, stop, -1, -1, act); m_frame(d, stop); is_rd = 1'b0; end
            OP_RDD:    begin cpu_read(1'b1, 1'b0, act); mexp = m_rd_data(); end
            OP_RDS:    begin cpu_read(1'b0, 1'b1, act); mexp = m_rd_stat(); end
            OP_RDB:    begin cpu_read(1'b1, 1'b1, act); mexp = m_rd_data(); end
            default:   begin glitch(); is_rd = 1'b0; end
        endcase
    endtask

    typedef struct {
        op_t         op;
        logic [7:0]  data;
        logic        stop;
        logic [31:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[21];

    initial begin
        logic [31:0] act, mexp, cap;
        logic        is_rd;
        op_t         op;
        int          r;

        tbl[0]  = '{OP_SEND,   8'h55, 1'b1, 32'h0,   1'b1};
        tbl[1]  = '{OP_RDS,    8'h00, 1'b1, 32'h1,   1'b1};
        tbl[2]  = '{OP_RDD,    8'h00, 1'b1, 32'h155, 1'b0};
        tbl[3]  = '{OP_RDS,    8'h00, 1'b1, 32'h0,   1'b0};
        tbl[4]  = '{OP_GLITCH, 8'h00, 1'b1, 32'h0,   1'b0};
        tbl[5]  = '{OP_RDS,    8'h00, 1'b1, 32'h0,   1'b0};
        tbl[6]  = '{OP_SEND,   8'hA5, 1'b0, 32'h0,   1'b0};
        tbl[7]  = '{OP_RDS,    8'h00, 1'b1, 32'h8,   1'b0};
        tbl[8]  = '{OP_RDS,    8'h00, 1'b1, 32'h0,   1'b0};
        tbl[9]  = '{OP_SEND,   8'h01, 1'b1, 32'h0,   1'b1};
        tbl[10] = '{OP_SEND,   8'h02, 1'b1, 32'h0,   1'b1};
        tbl[11] = '{OP_SEND,   8'h03, 1'b1, 32'h0,   1'b1};
        tbl[12] = '{OP_SEND,   8'h04, 1'b1, 32'h0,   1'b1};
        tbl[13] = '{OP_SEND,   8'h05, 1'b1, 32'h0,   1'b1};
        tbl[14] = '{OP_RDS,    8'h00, 1'b1, 32'h7,   1'b1};
        tbl[15] = '{OP_RDD,    8'h00, 1'b1, 32'h101, 1'b1};
        tbl[16] = '{OP_RDD,    8'h00, 1'b1, 32'h102, 1'b1};
        tbl[17] = '{OP_RDD,    8'h00, 1'b1, 32'h103, 1'b1};
        tbl[18] = '{OP_RDD,    8'h00, 1'b1, 32'h104, 1'b0};
        tbl[19] = '{OP_RDD,    8'h00, 1'b1, 32'h0,   1'b0};
        tbl[20] = '{OP_RDS,    8'h00, 1'b1, 32'h0,   1'b0};

        resetn = 1'b0; rxd = 1'b1; sel_data = 1'b0; sel_stat = 1'b0; rstrb = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_irq", 32'(rx_irq), 32'h0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Directed table.
        for (int i = 0; i < 21; i++) begin
            do_op(tbl[i].op, tbl[i].data, tbl[i].stop, act, mexp, is_rd);
            if (is_rd) check($sformatf("tbl%0d_rdata", i), act, tbl[i].exp);
            check($sformatf("tbl%0d_irq", i), 32'(rx_irq), 32'(tbl[i].exp_irq));
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 3)      op = OP_SEND;
            else if (r <= 5) op = OP_RDD;
            else if (r <= 7) op = OP_RDS;
            else if (r == 8) op = OP_RDB;
            else             op = OP_GLITCH;
            do_op(op, 8'($urandom), $urandom_range(0, 7) != 0, act, mexp, is_rd);
            if (is_rd) check($sformatf("rnd%0d_rdata", i), act, mexp);
            check($sformatf("rnd%0d_irq", i), 32'(rx_irq), 32'(m_q.size() != 0));
        end

        // Drain to a clean state.
        for (int i = 0; i < DEPTH + 1; i++) begin
            do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd);
            check("drain_rdata", act, mexp);
        end
        do_op(OP_RDS, 8'h0, 1'b1, act, mexp, is_rd);
        check("drain_stat", act, mexp);

        // Full FIFO with a DATA read landing on the stop-bit sample cycle.
        for (int i = 1; i <= 4; i++) do_op(OP_SEND, 8'(i * 17), 1'b1, act, mexp, is_rd);
        send_frame(8'h99, 1'b1, 97, -1, cap);
        check("poppush_rdata", cap, 32'h111);
        void'(m_rd_data());
        m_frame(8'h99, 1'b1);
        check("poppush_irq", 32'(rx_irq), 32'h1);
        do_op(OP_RDS, 8'h0, 1'b1, act, mexp, is_rd);
        check("poppush_stat", act, 32'h3);
        do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd); check("popush_d1", act, 32'h122);
        do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd); check("popush_d2", act, 32'h133);
        do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd); check("popush_d3", act, 32'h144);
        do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd); check("popush_d4", act, 32'h199);

        // Reset mid-frame discards both queued data and the partial frame.
        do_op(OP_SEND, 8'h77, 1'b1, act, mexp, is_rd);
        send_frame(8'h3C, 1'b1, -1, 50, cap);
        m_q.delete(); m_ovr = 1'b0; m_fe = 1'b0;
        check("abort_irq", 32'(rx_irq), 32'h0);
        check("abort_rdata", rdata, 32'h0);
        do_op(OP_SEND, 8'hC3, 1'b1, act, mexp, is_rd);
        do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd); check("abort_d1", act, 32'h1C3);
        do_op(OP_RDD, 8'h0, 1'b1, act, mexp, is_rd); check("abort_d2", act, 32'h0);
        do_op(OP_RDS, 8'h0, 1'b1, act, mexp, is_rd); check("abort_stat", act, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
